// File: rtl/cla_pipe_addsub_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_pipe_addsub_pkg;

    localparam int CLA_GROUP_DEFAULT = 4;
    localparam int CLA_WIDTH_DEFAULT = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_pipe_addsub_group.sv
// Combinational GROUP-bit carry-lookahead slice with group propagate/generate.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             c_msb_in,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] bit_p;
    logic [GROUP-1:0] bit_g;
    logic [GROUP:0]   c;

    // g accumulates the group generate as if the carry-in were zero.
    always_comb begin
        bit_p = a ^ b;
        bit_g = a & b;
        c     = '0;
        c[0]  = c_in;
        g     = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = bit_g[i] | (bit_p[i] & c[i]);
            g      = bit_g[i] | (bit_p[i] & g);
        end
        p        = &bit_p;
        s        = bit_p ^ c[GROUP-1:0];
        c_out    = c[GROUP];
        c_msb_in = c[GROUP-1];
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: one GROUP-bit slice resolved per stage,
// valid/ready on both sides, whole-pipe stall under backpressure.
module cla_pipe_addsub
    import cla_pipe_addsub_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH_DEFAULT,
    parameter int GROUP = CLA_GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int GROUP_SAFE = (GROUP > 0) ? GROUP : 1;
    localparam int NGROUPS    = WIDTH / GROUP_SAFE;

    if (GROUP < 1 || (WIDTH % GROUP_SAFE) != 0) begin : g_param_check
        $error("cla_pipe_addsub: WIDTH must be a positive multiple of GROUP");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;
    assign b_eff    = b ^ {WIDTH{sub}};
    assign c0       = cin ^ sub;

    // Each stage consumes the low GROUP bits of its skewed operands and
    // forwards the rest; the partial sum grows by GROUP bits per stage.
    for (genvar k = 0; k < NGROUPS; k++) begin : stage
        localparam int LO   = k * GROUP_SAFE;
        localparam int IN_W = WIDTH - LO;

        logic [IN_W-1:0]       a_in;
        logic [IN_W-1:0]       b_in;
        logic                  c_in;
        logic                  v_in;
        logic [LO+GROUP_SAFE-1:0] sum_next;
        logic [GROUP_SAFE-1:0] grp_s;
        logic                  grp_cout;
        logic                  grp_cmsb;
        logic                  grp_p;
        logic                  grp_g;

        logic                  v_q;
        logic                  c_q;
        logic [LO+GROUP_SAFE-1:0] sum_q;

        if (k == 0) begin : g_src
            assign a_in     = a;
            assign b_in     = b_eff;
            assign c_in     = c0;
            assign v_in     = in_valid;
            assign sum_next = grp_s;
        end else begin : g_src
            assign a_in     = stage[k-1].g_fwd.a_q;
            assign b_in     = stage[k-1].g_fwd.b_q;
            assign c_in     = stage[k-1].c_q;
            assign v_in     = stage[k-1].v_q;
            assign sum_next = {grp_s, stage[k-1].sum_q};
        end

        cla_group #(
            .GROUP (GROUP_SAFE)
        ) u_group (
            .a        (a_in[GROUP_SAFE-1:0]),
            .b        (b_in[GROUP_SAFE-1:0]),
            .c_in     (c_in),
            .s        (grp_s),
            .c_out    (grp_cout),
            .c_msb_in (grp_cmsb),
            .p        (grp_p),
            .g        (grp_g)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                c_q   <= grp_cout;
                sum_q <= sum_next;
            end
        end

        if (k < NGROUPS - 1) begin : g_fwd
            logic [IN_W-GROUP_SAFE-1:0] a_q;
            logic [IN_W-GROUP_SAFE-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[IN_W-1:GROUP_SAFE];
                    b_q <= b_in[IN_W-1:GROUP_SAFE];
                end
            end
        end

        // Overflow needs the carries into and out of the MSB, both local here.
        if (k == NGROUPS - 1) begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= grp_cmsb ^ grp_cout;
                end
            end
        end
    end

    assign out_valid = stage[NGROUPS-1].v_q;
    assign s         = stage[NGROUPS-1].sum_q;
    assign cout      = stage[NGROUPS-1].c_q;
    assign ovf       = stage[NGROUPS-1].g_last.ovf_q;

endmodule
